// File: rtl/park_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : park_ctrl_multi_if
// Brief    : Lane-side bundle for the multi-slot car park controller.
//            master = lane/terminal side, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface park_ctrl_multi_if #(
  parameter int ID_W  = 4,
  parameter int FEE_W = 4
);
  logic              tick;
  logic              sin;
  logic              sout;
  logic [ID_W-1:0]   exit_id;
  logic              pay;
  logic              bin;
  logic              bout;
  logic [ID_W-1:0]   ticket_id;
  logic              ticket_vld;
  logic [FEE_W-1:0]  fee;
  logic              fee_vld;
  logic [ID_W:0]     free_cnt;
  logic              full;
  logic              err_id;

  modport master (
    output tick, sin, sout, exit_id, pay,
    input  bin, bout, ticket_id, ticket_vld, fee, fee_vld, free_cnt, full, err_id
  );

  modport slave (
    input  tick, sin, sout, exit_id, pay,
    output bin, bout, ticket_id, ticket_vld, fee, fee_vld, free_cnt, full, err_id
  );
endinterface
`default_nettype wire

// File: rtl/park_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : park_ctrl_multi
// Brief    : Multi-slot car park controller: ticketing, capped hourly fee,
//            pay handshake and timed barriers. Optional free-exit grace
//            window enabled by defining PARK_GRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module park_ctrl_multi #(
  parameter int NUM_SLOTS      = 5,
  parameter int ID_W           = 4,
  parameter int TIME_W         = 16,
  parameter int TICKS_PER_HOUR = 3600,
  parameter int MAX_FEE        = 5,
  parameter int FEE_W          = 4,
  parameter int BAR_TICKS      = 5,
  parameter int GRACE_TICKS    = 600
) (
  input  wire logic         clk,
  input  wire logic         rst,
  park_ctrl_multi_if.slave  bus
);

  localparam int c_bar_cw = (BAR_TICKS > 1) ? $clog2(BAR_TICKS) : 1;

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_entry    = 3'd1;
  localparam logic [2:0] c_st_bar_in   = 3'd2;
  localparam logic [2:0] c_st_exit_chk = 3'd3;
  localparam logic [2:0] c_st_calc     = 3'd4;
  localparam logic [2:0] c_st_quote    = 3'd5;
  localparam logic [2:0] c_st_bar_out  = 3'd6;

  localparam logic [ID_W:0]     c_num_slots = (ID_W+1)'(NUM_SLOTS);
  localparam logic [TIME_W-1:0] c_tph       = TIME_W'(TICKS_PER_HOUR);
  localparam logic [FEE_W-1:0]  c_max_fee   = FEE_W'(MAX_FEE);
  localparam logic [c_bar_cw-1:0] c_bar_last = c_bar_cw'(BAR_TICKS - 1);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || (1 << ID_W) < NUM_SLOTS ||
      MAX_FEE < 1 || MAX_FEE > ((1 << FEE_W) - 1) || BAR_TICKS < 1 ||
      TICKS_PER_HOUR < 1 || GRACE_TICKS < 0) begin : g_param_err
    $error("park_ctrl_multi: illegal parameter combination");
  end

  logic [2:0]          r_state;
  logic                r_sin_q;
  logic                r_sout_q;
  logic                r_ent_pend;
  logic                r_ext_pend;
  logic [ID_W-1:0]     r_exit_id;
  logic [ID_W-1:0]     r_cur_id;
  logic [TIME_W-1:0]   r_t;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [TIME_W-1:0]   r_tent [NUM_SLOTS];
  logic [ID_W:0]       r_free_cnt;
  logic                r_full;
  logic                r_bin;
  logic                r_bout;
  logic [ID_W-1:0]     r_ticket_id;
  logic                r_ticket_vld;
  logic [FEE_W-1:0]    r_fee;
  logic                r_fee_vld;
  logic                r_err_id;
  logic [c_bar_cw-1:0] r_bar_cnt;
  logic [TIME_W-1:0]   r_rem;
  logic [FEE_W-1:0]    r_fee_acc;
`ifdef PARK_GRACE_EN
  logic                r_grace;
`endif

  logic                w_sin_rise;
  logic                w_sout_rise;
  logic [ID_W-1:0]     w_free_idx;
  logic                w_cur_occ;
  logic [TIME_W-1:0]   w_cur_tent;
  logic [TIME_W-1:0]   w_elapsed;
  logic                w_alloc;
  logic                w_release;
  logic                w_ext_clr;
  logic                w_bar_last;

  assign w_sin_rise  = bus.sin  & ~r_sin_q;
  assign w_sout_rise = bus.sout & ~r_sout_q;
  assign w_bar_last  = (r_bar_cnt == c_bar_last);

  // Lowest-index free slot; only consumed in ENTRY, which requires !full.
  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_occ[i]) w_free_idx = ID_W'(i);
    end
  end

  // Ids at or beyond NUM_SLOTS never match, so they read as unoccupied.
  always_comb begin
    w_cur_occ  = 1'b0;
    w_cur_tent = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_cur_id == ID_W'(i)) begin
        w_cur_occ  = r_occ[i];
        w_cur_tent = r_tent[i];
      end
    end
  end

  assign w_elapsed = r_t - w_cur_tent;
  assign w_alloc   = (r_state == c_st_entry);
`ifdef PARK_GRACE_EN
  assign w_release = ((r_state == c_st_quote) && bus.pay) ||
                     ((r_state == c_st_calc) && r_grace);
`else
  assign w_release = (r_state == c_st_quote) && bus.pay;
`endif
  assign w_ext_clr = ((r_state == c_st_exit_chk) && !w_cur_occ) || w_release;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sin_q    <= 1'b0;
      r_sout_q   <= 1'b0;
      r_ent_pend <= 1'b0;
      r_ext_pend <= 1'b0;
      r_exit_id  <= '0;
      r_t        <= '0;
    end else begin
      r_sin_q    <= bus.sin;
      r_sout_q   <= bus.sout;
      // A fresh edge wins over a same-cycle clear so that car is not lost.
      r_ent_pend <= w_sin_rise  | (r_ent_pend & ~w_alloc);
      r_ext_pend <= w_sout_rise | (r_ext_pend & ~w_ext_clr);
      if (w_sout_rise) r_exit_id <= bus.exit_id;
      if (bus.tick)    r_t <= r_t + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ      <= '0;
      r_free_cnt <= c_num_slots;
      r_full     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_tent[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_alloc && (w_free_idx == ID_W'(i))) begin
          r_occ[i]  <= 1'b1;
          r_tent[i] <= r_t;
        end else if (w_release && (r_cur_id == ID_W'(i))) begin
          r_occ[i]  <= 1'b0;
        end
      end
      if (w_alloc && (r_free_cnt != '0)) begin
        r_free_cnt <= r_free_cnt - 1'b1;
        r_full     <= (r_free_cnt == (ID_W+1)'(1));
      end else if (w_release && (r_free_cnt != c_num_slots)) begin
        r_free_cnt <= r_free_cnt + 1'b1;
        r_full     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_st_idle;
      r_cur_id     <= '0;
      r_bin        <= 1'b0;
      r_bout       <= 1'b0;
      r_ticket_id  <= '0;
      r_ticket_vld <= 1'b0;
      r_fee        <= '0;
      r_fee_vld    <= 1'b0;
      r_err_id     <= 1'b0;
      r_bar_cnt    <= '0;
      r_rem        <= '0;
      r_fee_acc    <= '0;
`ifdef PARK_GRACE_EN
      r_grace      <= 1'b0;
`endif
    end else begin
      r_ticket_vld <= 1'b0;
      r_err_id     <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (r_ext_pend) begin
            r_cur_id <= r_exit_id;
            r_state  <= c_st_exit_chk;
          end else if (r_ent_pend && !r_full) begin
            r_state  <= c_st_entry;
          end
        end
        c_st_entry: begin
          r_ticket_id  <= w_free_idx;
          r_ticket_vld <= 1'b1;
          r_bin        <= 1'b1;
          r_bar_cnt    <= '0;
          r_state      <= c_st_bar_in;
        end
        c_st_bar_in: begin
          if (bus.tick) begin
            if (w_bar_last) begin
              r_bin   <= 1'b0;
              r_state <= c_st_idle;
            end else begin
              r_bar_cnt <= r_bar_cnt + 1'b1;
            end
          end
        end
        c_st_exit_chk: begin
          if (!w_cur_occ) begin
            r_err_id <= 1'b1;
            r_state  <= c_st_idle;
          end else begin
            r_rem     <= w_elapsed;
            r_fee_acc <= FEE_W'(1);
`ifdef PARK_GRACE_EN
            r_grace   <= (w_elapsed < TIME_W'(GRACE_TICKS));
`endif
            r_state   <= c_st_calc;
          end
        end
        c_st_calc: begin
`ifdef PARK_GRACE_EN
          if (r_grace) begin
            r_fee     <= '0;
            r_bout    <= 1'b1;
            r_bar_cnt <= '0;
            r_state   <= c_st_bar_out;
          end else
`endif
          // One hour per cycle; stops early once the cap is reached.
          if ((r_rem >= c_tph) && (r_fee_acc < c_max_fee)) begin
            r_rem     <= r_rem - c_tph;
            r_fee_acc <= r_fee_acc + 1'b1;
          end else begin
            r_fee     <= r_fee_acc;
            r_fee_vld <= 1'b1;
            r_state   <= c_st_quote;
          end
        end
        c_st_quote: begin
          if (bus.pay) begin
            r_fee_vld <= 1'b0;
            r_bout    <= 1'b1;
            r_bar_cnt <= '0;
            r_state   <= c_st_bar_out;
          end
        end
        c_st_bar_out: begin
          if (bus.tick) begin
            if (w_bar_last) begin
              r_bout  <= 1'b0;
              r_fee   <= '0;
              r_state <= c_st_idle;
            end else begin
              r_bar_cnt <= r_bar_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.bin        = r_bin;
  assign bus.bout       = r_bout;
  assign bus.ticket_id  = r_ticket_id;
  assign bus.ticket_vld = r_ticket_vld;
  assign bus.fee        = r_fee;
  assign bus.fee_vld    = r_fee_vld;
  assign bus.free_cnt   = r_free_cnt;
  assign bus.full       = r_full;
  assign bus.err_id     = r_err_id;

endmodule
`default_nettype wire

// File: tb/tb_park_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_park_ctrl_multi
// Brief    : Directed, table-driven bench for park_ctrl_multi (4 slots,
//            10 ticks/hour, cap 5, 3-tick barriers, grace 5 with PARK_GRACE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_park_ctrl_multi;
  localparam int NUM_SLOTS = 4;
  localparam int ID_W      = 4;
  localparam int TIME_W    = 16;
  localparam int TPH       = 10;
  localparam int MAX_FEE   = 5;
  localparam int FEE_W     = 4;
  localparam int BAR_TICKS = 3;
  localparam int GRACE     = 5;
`ifdef PARK_GRACE_EN
  localparam bit GR = 1'b1;
`else
  localparam bit GR = 1'b0;
`endif

  typedef struct {
    int el;
    int fee;
    int fee_gr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [TIME_W-1:0] mt;
  logic [TIME_W-1:0] tent [16];

  park_ctrl_multi_if #(.ID_W(ID_W), .FEE_W(FEE_W)) bus ();

  park_ctrl_multi #(
    .NUM_SLOTS(NUM_SLOTS), .ID_W(ID_W), .TIME_W(TIME_W), .TICKS_PER_HOUR(TPH),
    .MAX_FEE(MAX_FEE), .FEE_W(FEE_W), .BAR_TICKS(BAR_TICKS), .GRACE_TICKS(GRACE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference time base: counts ticks exactly as the lane clock sees them.
  always @(posedge clk or negedge rst) begin
    if (!rst) mt <= '0;
    else if (bus.tick) mt <= mt + 1'b1;
  end

  function automatic int fee_of(input int el);
    int f;
    if (GR && el < GRACE) return 0;
    f = el / TPH + 1;
    return (f > MAX_FEE) ? MAX_FEE : f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic advance(input int n);
    bus.tick = 1'b1;
    repeat (n) cyc();
    bus.tick = 1'b0;
  endtask

  task automatic wait_entry(input int exp_id, input int exp_free, input bit count_bar);
    int n;
    n = 0;
    while (!bus.ticket_vld && n < 10) begin cyc(); n++; end
    chk("entry_ticket_vld", bus.ticket_vld, 1);
    chk("entry_ticket_id", bus.ticket_id, exp_id);
    chk("entry_bin_open", bus.bin, 1);
    chk("entry_free_cnt", bus.free_cnt, exp_free);
    tent[exp_id] = mt;
    if (count_bar) begin
      bus.tick = 1'b1;
      cyc();
      chk("ticket_vld_strobe", bus.ticket_vld, 0);
      n = 1;
      while (bus.bin && n < 20) begin cyc(); n++; end
      bus.tick = 1'b0;
      chk("bin_ticks", n, BAR_TICKS);
    end
  endtask

  task automatic do_entry(input int exp_id, input int exp_free);
    bus.tick = 1'b0;
    bus.sin  = 1'b1;
    cyc();
    bus.sin  = 1'b0;
    wait_entry(exp_id, exp_free, 1'b1);
  endtask

  task automatic do_exit(input int id, input int exp_fee, input int exp_free, input bit with_sin);
    int n;
    bit saw_tv;
    bit saw_fv;
    saw_tv = 1'b0;
    saw_fv = 1'b0;
    bus.tick    = 1'b0;
    bus.exit_id = ID_W'(id);
    bus.sout    = 1'b1;
    if (with_sin) bus.sin = 1'b1;
    cyc();
    bus.sout = 1'b0;
    bus.sin  = 1'b0;
    n = 0;
    while (!bus.fee_vld && !bus.bout && !bus.err_id && n < 20) begin
      cyc();
      n++;
      if (bus.ticket_vld) saw_tv = 1'b1;
    end
    chk("exit_served_first", saw_tv, 0);
    chk("exit_no_err", bus.err_id, 0);
    if (exp_fee == 0) begin
      chk("grace_fee_vld", bus.fee_vld, 0);
      chk("grace_bout", bus.bout, 1);
      chk("grace_fee", bus.fee, 0);
    end else begin
      chk("quote_fee_vld", bus.fee_vld, 1);
      chk("quote_fee", bus.fee, exp_fee);
      cyc();
      cyc();
      chk("quote_waits_pay", {bus.fee_vld, bus.bout, bus.fee}, {1'b1, 1'b0, 4'(exp_fee)});
      bus.pay = 1'b1;
      cyc();
      bus.pay = 1'b0;
      chk("pay_fee_vld_low", bus.fee_vld, 0);
      chk("pay_bout", bus.bout, 1);
    end
    chk("exit_free_cnt", bus.free_cnt, exp_free);
    bus.tick = 1'b1;
    n = 0;
    while (bus.bout && n < 20) begin
      cyc();
      n++;
      if (bus.fee_vld) saw_fv = 1'b1;
    end
    bus.tick = 1'b0;
    chk("bout_ticks", n, BAR_TICKS);
    chk("bout_no_fee_vld", saw_fv, 0);
    chk("fee_cleared", bus.fee, 0);
  endtask

  task automatic do_err(input int id, input int exp_free);
    int n;
    bit bad;
    bad = 1'b0;
    bus.tick    = 1'b0;
    bus.exit_id = ID_W'(id);
    bus.sout    = 1'b1;
    cyc();
    bus.sout = 1'b0;
    n = 0;
    while (!bus.err_id && n < 10) begin
      cyc();
      n++;
      if (bus.fee_vld || bus.bout) bad = 1'b1;
    end
    chk("err_strobe", bus.err_id, 1);
    cyc();
    chk("err_one_cycle", bus.err_id, 0);
    repeat (3) begin
      cyc();
      if (bus.fee_vld || bus.bout) bad = 1'b1;
    end
    chk("err_no_fee_bout", bad, 0);
    chk("err_free_cnt", bus.free_cnt, exp_free);
  endtask

  initial begin
    vec_t vecs [9];
    bit   seen;
    vecs[0] = '{25, 3, 3};
    vecs[1] = '{10, 2, 2};
    vecs[2] = '{9, 1, 1};
    vecs[3] = '{200, 5, 5};
    vecs[4] = '{39, 4, 4};
    vecs[5] = '{49, 5, 5};
    vecs[6] = '{3, 1, 0};
    vecs[7] = '{5, 1, 1};
    vecs[8] = '{4, 1, 0};

    bus.tick = 1'b0; bus.sin = 1'b0; bus.sout = 1'b0;
    bus.exit_id = '0; bus.pay = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    chk("rst_bin", bus.bin, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_ticket_id", bus.ticket_id, 0);
    chk("rst_ticket_vld", bus.ticket_vld, 0);
    chk("rst_fee", bus.fee, 0);
    chk("rst_fee_vld", bus.fee_vld, 0);
    chk("rst_err_id", bus.err_id, 0);
    chk("rst_free_cnt", bus.free_cnt, NUM_SLOTS);
    chk("rst_full", bus.full, 0);

    // pay while idle must do nothing
    bus.pay = 1'b1;
    cyc();
    bus.pay = 1'b0;
    cyc();
    chk("idle_pay_ignored", {bus.bout, bus.fee_vld, bus.free_cnt}, {1'b0, 1'b0, 5'(NUM_SLOTS)});

    // two entries, then leave in reverse order
    do_entry(0, 3);
    do_entry(1, 2);
    advance(4);
    do_exit(1, fee_of(int'(mt - tent[1])), 3, 1'b0);
    do_exit(0, fee_of(int'(mt - tent[0])), 4, 1'b0);

    // fee table: elapsed measured from the entry timestamp
    for (int i = 0; i < 9; i++) begin
      do_entry(0, 3);
      advance(vecs[i].el - BAR_TICKS);
      chk("vec_elapsed", int'(mt - tent[0]), vecs[i].el);
      do_exit(0, GR ? vecs[i].fee_gr : vecs[i].fee, 4, 1'b0);
    end

    // fill the park; a further entry waits until slot 2 frees
    do_entry(0, 3);
    do_entry(1, 2);
    do_entry(2, 1);
    do_entry(3, 0);
    chk("full_set", bus.full, 1);
    bus.sin = 1'b1;
    cyc();
    bus.sin = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      cyc();
      if (bus.ticket_vld || bus.bin) seen = 1'b1;
    end
    chk("full_blocks_entry", seen, 0);
    chk("full_free_cnt", bus.free_cnt, 0);
    advance(5);
    do_exit(2, fee_of(int'(mt - tent[2])), 1, 1'b0);
    wait_entry(2, 0, 1'b1);
    chk("full_again", bus.full, 1);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      do_exit(i, fee_of(int'(mt - tent[i])), i + 1, 1'b0);
    end
    chk("drained_full", bus.full, 0);

    // invalid and unoccupied tickets
    do_err(7, 4);
    do_entry(0, 3);
    do_err(2, 3);
    do_exit(0, fee_of(int'(mt - tent[0])), 4, 1'b0);

    // simultaneous entry/exit, then reset in the middle of BAR_IN
    do_entry(0, 3);
    advance(12);
    do_exit(0, fee_of(int'(mt - tent[0])), 4, 1'b1);
    wait_entry(0, 3, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bin", bus.bin, 0);
    chk("async_rst_free_cnt", bus.free_cnt, NUM_SLOTS);
    chk("async_rst_ticket_vld", bus.ticket_vld, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    do_entry(0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/park_ctrl_multi.md
Name: park_ctrl_multi

Overview:
- Parametrised successor to the single-lane car park FSM. Manages NUM_SLOTS tracked parking slots, each with its own entry timestamp.
- Issues a ticket (slot index) on entry. Computes an hourly fee on exit, capped at MAX_FEE. Runs a pay handshake and times both barriers.
- Sits between the lane sensors/payment terminal and the barrier actuators, clocked by clk with a slow time-base strobe `tick`.

Parameters:
- NUM_SLOTS, 5, number of parking slots (2..16).
- ID_W, 4, ticket/slot id width; 2^ID_W >= NUM_SLOTS.
- TIME_W, 16, width of the global tick counter and stored timestamps.
- TICKS_PER_HOUR, 3600, ticks per billing hour.
- MAX_FEE, 5, fee cap in units.
- FEE_W, 4, fee output width; must hold MAX_FEE.
- BAR_TICKS, 5, ticks a barrier stays open.
- GRACE_TICKS, 600, free-exit window (used only with PARK_GRACE_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle time-base strobe
- sin  in  1  entry sensor, level
- sout  in  1  exit sensor, level
- exit_id  in  ID_W  ticket presented at exit; sampled on the sout rising edge
- pay  in  1  payment-done pulse
- bin  out  1  entry barrier open
- bout  out  1  exit barrier open
- ticket_id  out  ID_W  slot assigned on entry
- ticket_vld  out  1  one-cycle strobe qualifying ticket_id
- fee  out  FEE_W  amount due
- fee_vld  out  1  high while fee is presented and awaiting pay
- free_cnt  out  ID_W+1  free slots
- full  out  1  free_cnt==0
- err_id  out  1  one-cycle strobe on an invalid or unoccupied exit ticket

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all slots free, T=0, pending flags clear. Outputs: bin=0, bout=0, ticket_id=0, ticket_vld=0, fee=0, fee_vld=0, err_id=0, free_cnt=NUM_SLOTS, full=0. Reset mid-operation closes both barriers immediately and frees all slots.
- T increments on every tick and wraps modulo 2^TIME_W.
- Elapsed time = (T - t_entry) mod 2^TIME_W, so wrap is safe while a stay is shorter than 2^TIME_W ticks.
- Rising edge of sin sets ent_pend. Rising edge of sout sets ext_pend and captures exit_id.
- A held sensor never re-triggers. A pending flag set again while already set is absorbed.
- FSM states and transitions:
  - IDLE:
    - If ext_pend: go to EXIT_CHK. Exit has priority on simultaneous events.
    - Else if ent_pend and !full: go to ENTRY.
    - ent_pend while full stays pending until a slot frees.
  - ENTRY (1 cycle):
    - Allocate the lowest-index free slot and store t_entry=T.
    - ticket_id=slot, ticket_vld=1, free_cnt-1, clear ent_pend, bin=1.
    - Go to BAR_IN.
  - BAR_IN: bin held 1 for BAR_TICKS ticks, then bin=0, go to IDLE.
  - EXIT_CHK (1 cycle):
    - If id >= NUM_SLOTS or the slot is free: err_id=1, clear ext_pend, go to IDLE.
    - Else go to CALC.
  - CALC (iterative subtraction, no divider):
    - Initialise rem=elapsed, fee=1.
    - Each cycle: while rem >= TICKS_PER_HOUR and fee < MAX_FEE, subtract TICKS_PER_HOUR and increment fee.
    - Result: fee = min(floor(elapsed/TICKS_PER_HOUR)+1, MAX_FEE).
    - Latency <= MAX_FEE+1 cycles.
    - Go to QUOTE.
  - QUOTE: fee_vld=1, fee stable. On pay=1: fee_vld=0, free the slot, free_cnt+1, clear ext_pend, bout=1, go to BAR_OUT. pay outside QUOTE is ignored.
  - BAR_OUT: bout held 1 for BAR_TICKS ticks, then bout=0, fee=0, go to IDLE.
- full and free_cnt are registered and update the cycle after allocation or freeing.
- free_cnt never exceeds NUM_SLOTS and never underflows.

Optional Feature:
- Macro: PARK_GRACE_EN
- Defined: in CALC, if elapsed < GRACE_TICKS then fee=0. QUOTE is skipped (fee_vld stays 0) and the FSM goes directly to BAR_OUT, freeing the slot exactly as on pay.
- Undefined: GRACE_TICKS is unused; the minimum fee is 1.

Test Plan (NUM_SLOTS=4, TICKS_PER_HOUR=10, MAX_FEE=5, BAR_TICKS=3, tick every cycle):
1. Reset, then sin pulse → ticket_vld strobe with ticket_id=0, bin=1 for 3 ticks, free_cnt=3. Second sin pulse → ticket_id=1.
2. Entry at T=0; sout with exit_id=0 at T=25 → fee=3 with fee_vld=1. pay → bout=1 for 3 ticks, free_cnt restored. Exit at elapsed=10 → fee=2. Exit at elapsed=200 → fee=5 (cap).
3. Fill all 4 slots → full=1. sin pulse → no entry, ent_pend held. Exit slot 2 and pay → next entry issues ticket_id=2.
4. sout with exit_id=7, and separately exit_id of a free slot → err_id one-cycle strobe, no fee_vld, no bout, free_cnt unchanged.
5. sin and sout rising in the same cycle → exit served first, then entry. rst=0 asserted during BAR_IN → bin=0 asynchronously, free_cnt=4.
6. PARK_GRACE_EN with GRACE_TICKS=5: exit at elapsed=3 → fee=0, fee_vld never high, bout opens without pay. Exit at elapsed=7 → fee=1 and requires pay.
